mac_seq_ctrl: RTL and testbench
===============================

MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 SHALL have parameter W, default 4: signed width of each input and weight.
REQ-002 SHALL derive output width SW = 2*W+2 (10 at default); SW is not a free parameter.
REQ-003 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1: request a new 3-term weighted sum.
REQ-006 SHALL have ports A, B, C, input, W signed each: operands.
REQ-007 SHALL have ports peso_A, peso_B, peso_C, input, W signed each: weights.
REQ-008 SHALL have port S, output, SW signed: registered result.
REQ-009 SHALL have port busy, output, 1: high while a computation is in flight.
REQ-010 SHALL have port done, output, 1: one-cycle pulse when S is updated.

Function
REQ-011 SHALL compute S = A*peso_A + B*peso_B + C*peso_C using exactly one W x W signed multiplier, time-shared across the three terms.
REQ-012 SHALL implement FSM states IDLE, ACC0, ACC1, ACC2, DONE; IDLE->ACC0 on start, ACC0->ACC1->ACC2->DONE unconditionally, DONE->IDLE unconditionally.
REQ-013 SHALL latch all six operands and clear the SW-bit accumulator on the edge where start is sampled high in IDLE; later input changes SHALL NOT affect the running computation.
REQ-014 SHALL add A*peso_A in ACC0, B*peso_B in ACC1 and C*peso_C in ACC2, each product sign-extended to SW bits.
REQ-015 SHALL assert busy in ACC0, ACC1, ACC2 and DONE; deassert it in IDLE.
REQ-016 SHALL, in DONE, drive done=1 for exactly one cycle and present the final sum on S in that same cycle; latency is start sampled at edge t -> done high during cycle t+4.
REQ-017 SHALL hold S at its last value until the next DONE; S SHALL NOT change in IDLE or ACC states.
REQ-018 SHALL ignore start while busy=1, including during DONE; back-to-back runs need start high in IDLE, giving a minimum period of 5 cycles.
REQ-019 SHALL never overflow: products span -2^(2W-2)+... to 2^(2W-2); the sum of three fits in SW bits with no wrap or saturation needed.
REQ-020 SHALL treat a start held continuously high as one request per return to IDLE.

Reset
REQ-021 SHALL, on any clock edge with rst=1, force state IDLE, accumulator 0, S 0, busy 0, done 0, regardless of state.
REQ-022 SHALL abort an in-flight computation on rst with no done pulse; rst has priority over start.
REQ-023 SHALL accept start on the first edge after rst deasserts.

Configuration
REQ-024 SHALL support macro MAC_RELU_EN.
REQ-025 With MAC_RELU_EN defined, S SHALL take max(sum, 0) at DONE (negative results clamp to 0); without it, S SHALL be the signed sum unmodified.
REQ-026 SHALL keep timing, busy and done identical in both configurations.

Verification
REQ-027 A=2,B=-3,C=1, pesos 2,3,-4, start 1 cycle -> done at t+4, S=-9 (S=0 with MAC_RELU_EN).
REQ-028 A=-8,B=7,C=-2, pesos 1,-2,3 -> S=-28 (0 with relu); change inputs to all 7 during ACC1 -> S still -28.
REQ-029 A=B=C=5, pesos -1 -> S=-15; then A=B=C=4, pesos 4 -> S=48 in both configs; extremes A=B=C=-8, pesos -8 -> S=192.
REQ-030 Start pulsed during ACC1 and DONE -> ignored, exactly one done pulse; start held high 12 cycles -> done at cycles 4 and 9, busy low at 5 and 10.
REQ-031 rst asserted in ACC2 -> next cycle IDLE, S=0, busy=0, no done; start immediately after -> correct result 4 cycles later.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequential 3-term weighted sum S = A*peso_A + B*peso_B + C*peso_C
// built around a single W x W signed multiplier that is reused once per term.
// Optional build macro: MAC_RELU_EN (clamp negative results to 0 at DONE).
module mac_seq_ctrl #(
  parameter  int W  = 4,
  localparam int SW = 2*W+2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic signed [W-1:0]  A,
  input  logic signed [W-1:0]  B,
  input  logic signed [W-1:0]  C,
  input  logic signed [W-1:0]  peso_A,
  input  logic signed [W-1:0]  peso_B,
  input  logic signed [W-1:0]  peso_C,
  output logic signed [SW-1:0] S,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {IDLE, ACC0, ACC1, ACC2, DONE} state_t;

  state_t state, nstate;

  logic signed [W-1:0]    la, lb, lc, wa, wb, wc;
  logic signed [W-1:0]    mul_a, mul_b;
  logic signed [2*W-1:0]  prod;
  logic signed [SW-1:0]   prod_x, acc, sum, res;

  // State register; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // Next-state and status outputs; start is only looked at in IDLE.
  always_comb begin
    nstate = state;
    busy   = 1'b1;
    done   = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) nstate = ACC0;
      end
      ACC0:    nstate = ACC1;
      ACC1:    nstate = ACC2;
      ACC2:    nstate = DONE;
      DONE: begin
        done   = 1'b1;
        nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  // Operand select for the shared multiplier: one term per ACC state.
  always_comb begin
    mul_a = la;
    mul_b = wa;
    case (state)
      ACC1: begin mul_a = lb; mul_b = wb; end
      ACC2: begin mul_a = lc; mul_b = wc; end
      default: begin mul_a = la; mul_b = wa; end
    endcase
  end

  assign prod   = mul_a * mul_b;
  assign prod_x = {{(SW-2*W){prod[2*W-1]}}, prod};
  assign sum    = acc + prod_x;

  // Final result shaping; three products of 2W bits always fit in SW bits.
`ifdef MAC_RELU_EN
  assign res = sum[SW-1] ? '0 : sum;
`else
  assign res = sum;
`endif

  // Operand capture, accumulation, and result register. S is written on the
  // edge into DONE so it is valid in the same cycle done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      S   <= '0;
      la  <= '0; lb <= '0; lc <= '0;
      wa  <= '0; wb <= '0; wc <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            la  <= A;      lb <= B;      lc <= C;
            wa  <= peso_A; wb <= peso_B; wc <= peso_C;
            acc <= '0;
          end
        end
        ACC0, ACC1: acc <= sum;
        ACC2: begin
          acc <= sum;
          S   <= res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl: directed cases plus random traffic,
// checked every cycle against a phase-count reference model.
module tb_mac_seq_ctrl;
  localparam int W  = 4;
  localparam int SW = 2*W+2;

  logic clk = 1'b0;
  logic rst, start;
  logic signed [W-1:0]  A, B, C, peso_A, peso_B, peso_C;
  logic signed [SW-1:0] S;
  logic busy, done;

  int errs   = 0;
  int checks = 0;

  // reference model: ph = 0 idle, 1..4 = cycles since accepted start
  int ph   = 0;
  int msum = 0;
  int ms   = 0;

  mac_seq_ctrl #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .A(A), .B(B), .C(C),
    .peso_A(peso_A), .peso_B(peso_B), .peso_C(peso_C),
    .S(S), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int relu(input int v);
`ifdef MAC_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_in(input int a, input int b, input int c,
                        input int pa, input int pb, input int pc);
    A = W'(a); B = W'(b); C = W'(c);
    peso_A = W'(pa); peso_B = W'(pb); peso_C = W'(pc);
  endtask

  // one clock: advance the model with pre-edge inputs, then compare outputs
  task automatic step();
    @(posedge clk);
    if (rst) begin
      ph = 0; ms = 0;
    end else if (ph == 0) begin
      if (start) begin
        msum = int'(A) * int'(peso_A) + int'(B) * int'(peso_B) + int'(C) * int'(peso_C);
        ph = 1;
      end
    end else if (ph == 4) begin
      ph = 0;
    end else begin
      ph++;
      if (ph == 4) ms = relu(msum);
    end
    #1;
    chk("busy", int'(busy), int'(ph != 0));
    chk("done", int'(done), int'(ph == 4));
    chk("S",    int'(S),    ms);
  endtask

  // single-cycle start, wait (bounded) for done, compare S to a constant
  task automatic run_op(input string tag, input int a, input int b, input int c,
                        input int pa, input int pb, input int pc,
                        input int exp_s, input bit mangle);
    bit found;
    int lat;
    set_in(a, b, c, pa, pb, pc);
    start = 1'b1;
    step();
    start = 1'b0;
    found = 1'b0;
    lat   = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (mangle && i == 1) set_in(7, 7, 7, 7, 7, 7);
      step();
      if (done) begin
        found = 1'b1;
        lat   = i + 2;
      end
    end
    if (!found) chk({tag, "_timeout"}, 0, 1);
    else begin
      chk({tag, "_S"}, int'(S), exp_s);
      chk({tag, "_lat"}, lat, 4);
    end
    step();
  endtask

  initial begin
    int ndone, d1, d2;
    rst = 1'b1; start = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    step(); step();
    chk("rst_S", int'(S), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;

    // directed values
    run_op("ex1", 2, -3, 1, 2, 3, -4, relu(-9), 1'b0);
    run_op("ex2", -8, 7, -2, 1, -2, 3, relu(-28), 1'b1);
    run_op("ex3", 5, 5, 5, -1, -1, -1, relu(-15), 1'b0);
    run_op("ex4", 4, 4, 4, 4, 4, 4, 48, 1'b0);
    run_op("ext", -8, -8, -8, -8, -8, -8, 192, 1'b0);

    // start pulses during ACC1 and DONE must be ignored
    set_in(3, 2, 1, 1, 2, 3);
    start = 1'b1; step(); start = 1'b0;      // ACC0
    ndone = 0;
    step();                                  // ACC1
    start = 1'b1; step(); start = 1'b0;      // sampled in ACC1 -> ACC2
    step();                                  // DONE
    if (done) ndone++;
    start = 1'b1; step(); start = 1'b0;      // sampled in DONE -> IDLE
    if (done) ndone++;
    for (int i = 0; i < 6; i++) begin step(); if (done) ndone++; end
    chk("ign_dones", ndone, 1);
    chk("ign_S", int'(S), 10);

    // start held high: one request per return to IDLE
    set_in(1, 1, 1, 1, 1, 1);
    start = 1'b1;
    ndone = 0; d1 = -1; d2 = -1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (done) begin
        ndone++;
        if (d1 < 0) d1 = k; else d2 = k;
      end
      if (k == 5 || k == 10) chk("held_busy_low", int'(busy), 0);
    end
    start = 1'b0;
    chk("held_ndone", ndone, 2);
    chk("held_d1", d1, 4);
    chk("held_d2", d2, 9);
    for (int i = 0; i < 5; i++) step();

    // reset during ACC2 aborts, then restart right away
    set_in(2, 2, 2, 2, 2, 2);
    start = 1'b1; step(); start = 1'b0;
    step(); step();                          // now in ACC2
    rst = 1'b1; step(); rst = 1'b0;
    chk("abort_S", int'(S), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    run_op("post_rst", 2, -3, 1, 2, 3, -4, relu(-9), 1'b0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(15), $urandom_range(15), $urandom_range(15),
             $urandom_range(15), $urandom_range(15), $urandom_range(15));
      if (A[W-1]) A = A; // keep full signed range via 4-bit wrap
      start = ($urandom_range(2) == 0);
      rst   = ($urandom_range(49) == 0);
      step();
    end
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 6; i++) step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
